// File: rtl/instruction_disassembler.sv
// RV32I instruction disassembler: takes one instruction word and streams its
// canonical assembly text as ASCII characters over a valid/ready handshake.
module instruction_disassembler #(
    parameter bit EMIT_NEWLINE = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        inst_valid_in,
    output logic        inst_ready_out,
    input  logic [31:0] instruction_in,
    output logic        char_valid_out,
    input  logic        char_ready_in,
    output logic [7:0]  outgoing_character,
    output logic        done_flag,
    output logic        error_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EMIT_MNEM,
        S_EMIT_OPS,
        S_EMIT_NL,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_MEM,
        FMT_STORE,
        FMT_B,
        FMT_J,
        FMT_U
    } fmt_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_inst;
    logic [7:0]  r_text [0:31];
    logic [4:0]  r_idx;
    logic [4:0]  r_mnemLast;
    logic [4:0]  r_lineLast;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immJ;
    logic [31:0] w_immU;

    logic        w_ok;
    fmt_t        w_fmt;
    logic [39:0] w_mnem;
    logic [2:0]  w_mnemLen;
    logic [31:0] w_imm;
    logic        w_immNeg;
    logic [31:0] w_immMag;
    logic [7:0]  w_immChr [0:15];
    logic [3:0]  w_immLen;
    logic [3:0]  w_immPos;
    logic [4:0]  w_r1;
    logic [4:0]  w_r2;
    logic [4:0]  w_r3;
    logic [23:0] w_r1Tok;
    logic [23:0] w_r2Tok;
    logic [23:0] w_r3Tok;
    logic [1:0]  w_r1Len;
    logic [1:0]  w_r2Len;
    logic [1:0]  w_r3Len;
    logic [7:0]  w_text [0:31];
    logic [5:0]  w_pos;

    function automatic logic [7:0] decChar(input logic [3:0] d);
        decChar = 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        hexChar = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Register name left-justified in 3 bytes: "x" plus one or two decimal digits.
    function automatic logic [23:0] regTok(input logic [4:0] r);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(r / 5'd10);
        ones = 4'(r % 5'd10);
        if (r >= 5'd10) regTok = {8'h78, decChar(tens), decChar(ones)};
        else            regTok = {8'h78, decChar(ones), 8'h00};
    endfunction

    function automatic logic [1:0] regLen(input logic [4:0] r);
        regLen = (r >= 5'd10) ? 2'd3 : 2'd2;
    endfunction

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_funct3 = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_funct7 = r_inst[31:25];
    assign w_immI   = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_immS   = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_immB   = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_immJ   = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
    assign w_immU   = {12'h000, r_inst[31:12]};

    // Mnemonics are held left-justified and zero-padded to five characters.
    always_comb begin
        w_ok   = 1'b1;
        w_fmt  = FMT_R;
        w_mnem = 40'h0;
        w_imm  = 32'h0;
        case (w_opcode)
            7'b0110011: begin
                w_fmt = FMT_R;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'd0: w_mnem = {"add", 16'h0};
                        3'd1: w_mnem = {"sll", 16'h0};
                        3'd2: w_mnem = {"slt", 16'h0};
                        3'd3: w_mnem = {"sltu", 8'h0};
                        3'd4: w_mnem = {"xor", 16'h0};
                        3'd5: w_mnem = {"srl", 16'h0};
                        3'd6: w_mnem = {"or", 24'h0};
                        3'd7: w_mnem = {"and", 16'h0};
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'd0) begin
                    w_mnem = {"sub", 16'h0};
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'd5) begin
                    w_mnem = {"sra", 16'h0};
                end else begin
                    w_ok = 1'b0;
                end
            end
            7'b0010011: begin
                w_fmt = FMT_I;
                w_imm = w_immI;
                case (w_funct3)
                    3'd0: w_mnem = {"addi", 8'h0};
                    3'd2: w_mnem = {"slti", 8'h0};
                    3'd3: w_mnem = "sltiu";
                    3'd4: w_mnem = {"xori", 8'h0};
                    3'd6: w_mnem = {"ori", 16'h0};
                    3'd7: w_mnem = {"andi", 8'h0};
                    3'd1: begin
                        w_imm = {27'h0, w_rs2};
                        if (w_funct7 == 7'b0000000) w_mnem = {"slli", 8'h0};
                        else                        w_ok = 1'b0;
                    end
                    3'd5: begin
                        w_imm = {27'h0, w_rs2};
                        if (w_funct7 == 7'b0000000)      w_mnem = {"srli", 8'h0};
                        else if (w_funct7 == 7'b0100000) w_mnem = {"srai", 8'h0};
                        else                             w_ok = 1'b0;
                    end
                endcase
            end
            7'b0000011: begin
                w_fmt = FMT_MEM;
                w_imm = w_immI;
                case (w_funct3)
                    3'd0:    w_mnem = {"lb", 24'h0};
                    3'd1:    w_mnem = {"lh", 24'h0};
                    3'd2:    w_mnem = {"lw", 24'h0};
                    3'd4:    w_mnem = {"lbu", 16'h0};
                    3'd5:    w_mnem = {"lhu", 16'h0};
                    default: w_ok = 1'b0;
                endcase
            end
            7'b0100011: begin
                w_fmt = FMT_STORE;
                w_imm = w_immS;
                case (w_funct3)
                    3'd0:    w_mnem = {"sb", 24'h0};
                    3'd1:    w_mnem = {"sh", 24'h0};
                    3'd2:    w_mnem = {"sw", 24'h0};
                    default: w_ok = 1'b0;
                endcase
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_imm = w_immB;
                case (w_funct3)
                    3'd0:    w_mnem = {"beq", 16'h0};
                    3'd1:    w_mnem = {"bne", 16'h0};
                    3'd4:    w_mnem = {"blt", 16'h0};
                    3'd5:    w_mnem = {"bge", 16'h0};
                    3'd6:    w_mnem = {"bltu", 8'h0};
                    3'd7:    w_mnem = {"bgeu", 8'h0};
                    default: w_ok = 1'b0;
                endcase
            end
            7'b0110111: begin
                w_fmt  = FMT_U;
                w_imm  = w_immU;
                w_mnem = {"lui", 16'h0};
            end
            7'b0010111: begin
                w_fmt  = FMT_U;
                w_imm  = w_immU;
                w_mnem = "auipc";
            end
            7'b1101111: begin
                w_fmt  = FMT_J;
                w_imm  = w_immJ;
                w_mnem = {"jal", 16'h0};
            end
            7'b1100111: begin
                w_fmt  = FMT_MEM;
                w_imm  = w_immI;
                w_mnem = {"jalr", 8'h0};
                if (w_funct3 != 3'd0) w_ok = 1'b0;
            end
            default: w_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_mnemLen = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (w_mnem[39 - 8*k -: 8] != 8'h00) w_mnemLen = 3'(k + 1);
        end
    end

    // U-type and shamt values are zero-extended, so bit 31 alone marks a negative immediate.
    always_comb begin
        logic [3:0] nib;
        logic       started;
        for (int k = 0; k < 16; k++) w_immChr[k] = 8'h00;
        w_immNeg = w_imm[31];
        w_immMag = w_immNeg ? (~w_imm + 32'd1) : w_imm;
        w_immPos = 4'd0;
        started  = 1'b0;
        nib      = 4'h0;
        if (w_immNeg) begin
            w_immChr[w_immPos] = 8'h2D;
            w_immPos = w_immPos + 4'd1;
        end
        w_immChr[w_immPos] = 8'h30;
        w_immPos = w_immPos + 4'd1;
        w_immChr[w_immPos] = 8'h78;
        w_immPos = w_immPos + 4'd1;
        for (int d = 7; d >= 0; d--) begin
            nib = w_immMag[4*d +: 4];
            if (nib != 4'h0 || started || d == 0) begin
                w_immChr[w_immPos] = hexChar(nib);
                w_immPos = w_immPos + 4'd1;
                started  = 1'b1;
            end
        end
        w_immLen = w_immPos;
    end

    assign w_r1    = (w_fmt == FMT_STORE) ? w_rs2 : ((w_fmt == FMT_B) ? w_rs1 : w_rd);
    assign w_r2    = (w_fmt == FMT_B) ? w_rs2 : w_rs1;
    assign w_r3    = w_rs2;
    assign w_r1Tok = regTok(w_r1);
    assign w_r2Tok = regTok(w_r2);
    assign w_r3Tok = regTok(w_r3);
    assign w_r1Len = regLen(w_r1);
    assign w_r2Len = regLen(w_r2);
    assign w_r3Len = regLen(w_r3);

    // The whole line (without terminator) is assembled here and latched at the end of DECODE.
    always_comb begin
        for (int k = 0; k < 32; k++) w_text[k] = 8'h00;
        w_pos = 6'd0;
        for (int k = 0; k < 5; k++) begin
            if (3'(k) < w_mnemLen) begin
                w_text[w_pos[4:0]] = w_mnem[39 - 8*k -: 8];
                w_pos = w_pos + 6'd1;
            end
        end
        w_text[w_pos[4:0]] = 8'h20;
        w_pos = w_pos + 6'd1;
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < w_r1Len) begin
                w_text[w_pos[4:0]] = w_r1Tok[23 - 8*k -: 8];
                w_pos = w_pos + 6'd1;
            end
        end
        w_text[w_pos[4:0]] = 8'h2C;
        w_pos = w_pos + 6'd1;
        w_text[w_pos[4:0]] = 8'h20;
        w_pos = w_pos + 6'd1;
        if (w_fmt == FMT_MEM || w_fmt == FMT_STORE) begin
            for (int k = 0; k < 11; k++) begin
                if (4'(k) < w_immLen) begin
                    w_text[w_pos[4:0]] = w_immChr[k];
                    w_pos = w_pos + 6'd1;
                end
            end
            w_text[w_pos[4:0]] = 8'h28;
            w_pos = w_pos + 6'd1;
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < w_r2Len) begin
                    w_text[w_pos[4:0]] = w_r2Tok[23 - 8*k -: 8];
                    w_pos = w_pos + 6'd1;
                end
            end
            w_text[w_pos[4:0]] = 8'h29;
            w_pos = w_pos + 6'd1;
        end else if (w_fmt == FMT_J || w_fmt == FMT_U) begin
            for (int k = 0; k < 11; k++) begin
                if (4'(k) < w_immLen) begin
                    w_text[w_pos[4:0]] = w_immChr[k];
                    w_pos = w_pos + 6'd1;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < w_r2Len) begin
                    w_text[w_pos[4:0]] = w_r2Tok[23 - 8*k -: 8];
                    w_pos = w_pos + 6'd1;
                end
            end
            w_text[w_pos[4:0]] = 8'h2C;
            w_pos = w_pos + 6'd1;
            w_text[w_pos[4:0]] = 8'h20;
            w_pos = w_pos + 6'd1;
            if (w_fmt == FMT_R) begin
                for (int k = 0; k < 3; k++) begin
                    if (2'(k) < w_r3Len) begin
                        w_text[w_pos[4:0]] = w_r3Tok[23 - 8*k -: 8];
                        w_pos = w_pos + 6'd1;
                    end
                end
            end else begin
                for (int k = 0; k < 11; k++) begin
                    if (4'(k) < w_immLen) begin
                        w_text[w_pos[4:0]] = w_immChr[k];
                        w_pos = w_pos + 6'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_nextState;
    end

    always_ff @(posedge clk_in) begin
        if (inst_valid_in && inst_ready_out) r_inst <= instruction_in;
        if (r_state == S_DECODE) begin
            r_text     <= w_text;
            r_mnemLast <= {2'b00, w_mnemLen} - 5'd1;
            r_lineLast <= w_pos[4:0] - 5'd1;
            r_idx      <= 5'd0;
        end else if (char_valid_out && char_ready_in) begin
            r_idx <= r_idx + 5'd1;
        end
    end

    always_comb begin
        w_nextState        = r_state;
        inst_ready_out     = 1'b0;
        char_valid_out     = 1'b0;
        outgoing_character = 8'h00;
        done_flag          = 1'b0;
        error_flag         = 1'b0;
        case (r_state)
            S_IDLE: begin
                inst_ready_out = 1'b1;
                if (inst_valid_in) w_nextState = S_DECODE;
            end
            S_DECODE: w_nextState = w_ok ? S_EMIT_MNEM : S_ERROR;
            S_EMIT_MNEM: begin
                char_valid_out     = 1'b1;
                outgoing_character = r_text[r_idx];
                if (char_ready_in && r_idx == r_mnemLast) w_nextState = S_EMIT_OPS;
            end
            S_EMIT_OPS: begin
                char_valid_out     = 1'b1;
                outgoing_character = r_text[r_idx];
                if (char_ready_in && r_idx == r_lineLast)
                    w_nextState = EMIT_NEWLINE ? S_EMIT_NL : S_DONE;
            end
            S_EMIT_NL: begin
                char_valid_out     = 1'b1;
                outgoing_character = 8'h0A;
                if (char_ready_in) w_nextState = S_DONE;
            end
            S_DONE: begin
                done_flag   = 1'b1;
                w_nextState = S_IDLE;
            end
            S_ERROR: begin
                error_flag  = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_disassembler.sv
// Directed bench for instruction_disassembler: feeds known RV32I words and
// compares the streamed text, handshake timing and flag pulses against hand-derived values.
module tb_instruction_disassembler;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        inst_valid_in = 1'b0;
    logic        inst_ready_out;
    logic [31:0] instruction_in = 32'h0;
    logic        char_valid_out;
    logic        char_ready_in = 1'b1;
    logic [7:0]  outgoing_character;
    logic        done_flag;
    logic        error_flag;

    int    passCount = 0;
    int    checkCount = 0;
    string lineText;
    bit    gotDone;
    bit    gotError;
    bit    anyValid;
    bit    readyWhileBusy;
    bit    heldOk;
    logic  flagAfter;
    logic  readyAfter;
    int    firstValid;
    int    doneGap;

    instruction_disassembler #(.EMIT_NEWLINE(1'b1)) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .inst_valid_in      (inst_valid_in),
        .inst_ready_out     (inst_ready_out),
        .instruction_in     (instruction_in),
        .char_valid_out     (char_valid_out),
        .char_ready_in      (char_ready_in),
        .outgoing_character (outgoing_character),
        .done_flag          (done_flag),
        .error_flag         (error_flag)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkText(input string tag, input string observed, input string expected);
        checkCount++;
        assert (observed == expected) passCount++;
        else $error("[TB] FAIL %s: observed \"%s\", expected \"%s\"", tag, observed, expected);
    endtask

    // Sends one word, then samples every falling edge until done/error or the cycle budget runs out.
    // stallAfter > 0 drops char_ready_in for three cycles after that many characters.
    task automatic applyStimulus(input logic [31:0] word, input int stallAfter);
        int         cyc;
        int         nChars;
        int         stallLeft;
        int         lastXfer;
        int         waitCnt;
        logic [7:0] heldChar;
        lineText       = "";
        gotDone        = 1'b0;
        gotError       = 1'b0;
        anyValid       = 1'b0;
        readyWhileBusy = 1'b0;
        heldOk         = 1'b1;
        firstValid     = -1;
        doneGap        = -1;
        flagAfter      = 1'bx;
        readyAfter     = 1'bx;
        waitCnt        = 0;
        while (!inst_ready_out && waitCnt < 20) begin
            @(negedge clk_in);
            waitCnt++;
        end
        inst_valid_in  = 1'b1;
        instruction_in = word;
        char_ready_in  = 1'b1;
        @(negedge clk_in);
        inst_valid_in  = 1'b0;
        instruction_in = 32'h0;
        cyc       = 1;
        nChars    = 0;
        stallLeft = 0;
        lastXfer  = -10;
        heldChar  = 8'h00;
        while (cyc < 200 && !gotDone && !gotError) begin
            char_ready_in = (stallLeft == 0);
            if (done_flag) begin
                gotDone = 1'b1;
                doneGap = cyc - lastXfer;
            end else if (error_flag) begin
                gotError = 1'b1;
            end else begin
                if (inst_ready_out) readyWhileBusy = 1'b1;
                if (char_valid_out) begin
                    anyValid = 1'b1;
                    if (firstValid < 0) firstValid = cyc;
                end
                if (stallLeft > 0) begin
                    if (!char_valid_out) heldOk = 1'b0;
                    if (stallLeft == 3) heldChar = outgoing_character;
                    else if (outgoing_character !== heldChar) heldOk = 1'b0;
                    stallLeft--;
                end else if (char_valid_out && char_ready_in) begin
                    lineText = $sformatf("%s%c", lineText, outgoing_character);
                    lastXfer = cyc;
                    nChars++;
                    if (nChars == stallAfter) stallLeft = 3;
                end
                @(negedge clk_in);
                cyc++;
            end
        end
        char_ready_in = 1'b1;
        if (gotDone || gotError) begin
            @(negedge clk_in);
            flagAfter  = done_flag | error_flag;
            readyAfter = inst_ready_out;
        end
    endtask

    initial begin
        int nx;
        bit sawFlag;

        rst_n_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("reset_inst_ready", {31'h0, inst_ready_out}, 32'h1);
        checkOutput("reset_char_valid", {31'h0, char_valid_out}, 32'h0);
        checkOutput("reset_char", {24'h0, outgoing_character}, 32'h0);
        checkOutput("reset_done", {31'h0, done_flag}, 32'h0);
        checkOutput("reset_error", {31'h0, error_flag}, 32'h0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        applyStimulus(32'h00500093, 0);
        checkText("addi_text", lineText, "addi x1, x0, 0x5\n");
        checkOutput("addi_done", {31'h0, gotDone}, 32'h1);
        checkOutput("addi_first_char_latency", firstValid, 32'd2);
        checkOutput("addi_done_after_nl", doneGap, 32'd1);
        checkOutput("addi_ready_low_while_busy", {31'h0, readyWhileBusy}, 32'h0);
        checkOutput("addi_done_one_cycle", {31'h0, flagAfter}, 32'h0);
        checkOutput("addi_ready_after", {31'h0, readyAfter}, 32'h1);

        applyStimulus(32'h40208033, 0);
        checkText("sub_text", lineText, "sub x0, x1, x2\n");
        checkOutput("sub_done", {31'h0, gotDone}, 32'h1);

        applyStimulus(32'h40725193, 0);
        checkText("srai_text", lineText, "srai x3, x4, 0x7\n");

        applyStimulus(32'hFFC12283, 0);
        checkText("lw_text", lineText, "lw x5, -0x4(x2)\n");

        applyStimulus(32'h12345537, 0);
        checkText("lui_text", lineText, "lui x10, 0x12345\n");

        applyStimulus(32'h00000463, 5);
        checkText("beq_stall_text", lineText, "beq x0, x0, 0x8\n");
        checkOutput("beq_stall_held", {31'h0, heldOk}, 32'h1);
        checkOutput("beq_done_after_nl", doneGap, 32'd1);

        applyStimulus(32'h80000013, 0);
        checkText("addi_min_imm_text", lineText, "addi x0, x0, -0x800\n");

        applyStimulus(32'hFFFFFFEF, 0);
        checkText("jal_x31_text", lineText, "jal x31, -0x2\n");

        applyStimulus(32'h00202023, 0);
        checkText("sw_zero_imm_text", lineText, "sw x2, 0x0(x0)\n");

        applyStimulus(32'hFFFFFFFF, 0);
        checkOutput("illegal_error", {31'h0, gotError}, 32'h1);
        checkOutput("illegal_no_char_valid", {31'h0, anyValid}, 32'h0);
        checkOutput("illegal_error_one_cycle", {31'h0, flagAfter}, 32'h0);
        checkOutput("illegal_ready_after", {31'h0, readyAfter}, 32'h1);

        applyStimulus(32'h02000033, 0);
        checkOutput("mul_funct7_error", {31'h0, gotError}, 32'h1);
        checkOutput("mul_no_char_valid", {31'h0, anyValid}, 32'h0);

        // Reset in the middle of a line after the third character has gone out.
        inst_valid_in  = 1'b1;
        instruction_in = 32'h00500093;
        char_ready_in  = 1'b1;
        @(negedge clk_in);
        inst_valid_in  = 1'b0;
        nx = 0;
        for (int c = 0; c < 50 && nx < 3; c++) begin
            if (char_valid_out && char_ready_in) nx++;
            @(negedge clk_in);
        end
        checkOutput("midreset_chars_before", nx, 32'd3);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        checkOutput("midreset_inst_ready", {31'h0, inst_ready_out}, 32'h1);
        checkOutput("midreset_char_valid", {31'h0, char_valid_out}, 32'h0);
        checkOutput("midreset_char", {24'h0, outgoing_character}, 32'h0);
        checkOutput("midreset_done", {31'h0, done_flag}, 32'h0);
        checkOutput("midreset_error", {31'h0, error_flag}, 32'h0);
        sawFlag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done_flag || error_flag || char_valid_out) sawFlag = 1'b1;
            @(negedge clk_in);
        end
        checkOutput("midreset_no_pulse", {31'h0, sawFlag}, 32'h0);

        applyStimulus(32'h40208033, 0);
        checkText("after_reset_sub_text", lineText, "sub x0, x1, x2\n");
        checkOutput("after_reset_sub_done", {31'h0, gotDone}, 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
